imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
- Inverse of the immediate extender: takes a 32-bit immediate value and an immediate-format select (same 3-bit encoding as the extender), and scatters the value into the immediate fields of a base instruction word.
- Used by the instruction-generation / self-test path to assemble RV32I instructions. It also checks that the value is representable in the chosen format.
- 2-stage valid/ready pipeline with full backpressure, a transaction counter and an error counter.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_immsrc  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 110/111 illegal
- in_imm  input  32  immediate value (byte offset for B/J)
- in_base  input  32  instruction word; non-immediate bits (opcode, rd, rs1, rs2, funct3, funct7) taken from here
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid & out_ready
- out_instr  output  32  packed instruction
- out_err  output  1  immediate not representable, or illegal format
- enc_cnt  output  CNT_W  output handshakes since reset; wraps at 2^CNT_W
- err_cnt  output  CNT_W  output handshakes with out_err=1; saturates at all-ones

Behaviour:
- Reset, asynchronous on rst_n low:
  - both stage valids = 0, so out_valid=0.
  - out_instr=0, out_err=0, enc_cnt=0, err_cnt=0.
  - in_ready=1 from the first clock edge after release.
  - A reset mid-operation drops in-flight items; no partial outputs.
- S1 registers {immsrc, imm, base}. S2 registers the packed instruction and error. Latency 2 cycles (accept edge to out_valid), with out_ready held high.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational)
  - Full throughput: 1 per cycle.
- Stall:
  - While out_valid & !out_ready, out_instr and out_err hold stable.
  - At most 2 items are buffered; none dropped or duplicated; order preserved.
- Packing. Every bit not listed comes from base.
  - I: [31:20]=imm[11:0]. err if imm[31:11] not all equal.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. err as I.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. err if imm[0]=1 or imm[31:12] not all equal.
  - U: [31:12]=imm[31:12]. err if imm[11:0]!=0.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. err if imm[0]=1 or imm[31:20] not all equal.
  - shamt: [24:20]=imm[4:0]. err if imm[31:5]!=0.
  - 110/111: out_instr=base, err=1.
- On err, the truncated fields are still packed as listed.
- Round-trip: for any err=0 result, the extender applied to out_instr[31:7] with the same immsrc returns in_imm.
- Counters:
  - Update only on the output handshake.
  - enc_cnt increments and wraps.
  - err_cnt increments when out_err=1 and saturates.
  - A reset coincident with a handshake wins (counters cleared).

Optional Feature:
- Macro IMM_PACKER_RANGE_CHECK_EN.
- Defined: range checks as above.
- Undefined:
  - Only the illegal-format check (110/111) sets out_err.
  - Out-of-range values are silently truncated into the fields.
  - err_cnt counts illegal formats only.

Test Plan:
- I, imm=0xFFFFFFFF, base=0x00000013 -> out_instr=0xFFF00013, err=0, out_valid exactly 2 cycles after accept.
- B, imm=0x00000010, base=0x00000063 -> 0x00000863, err=0. Then B, imm=0x00000003 -> err=1, err_cnt=1.
- U, imm=0x12345000, base=0x000000B7 -> 0x123450B7. J, imm=0x00000800, base=0x000000EF -> 0x001000EF. Both err=0.
- I, imm=0x00000800 -> err=1 with macro, err=0 without. immsrc=111 -> out_instr=base, err=1 in both builds.
- out_ready=0 for 5 cycles while offering 3 back-to-back requests:
  - exactly 2 accepted, then in_ready=0; out_instr stable.
  - on release, results in order over consecutive cycles; enc_cnt=3.
- rst_n pulsed low asynchronously between edges with 2 items in flight -> out_valid=0 and counters=0 immediately; no stale output after release. Random round-trip: 10k random (immsrc, imm) against the extender model.

Source files
------------

// File: rtl/imm_packer.sv
// imm_packer: scatters a 32-bit immediate into the immediate fields of a
// base RV32I instruction word. This is the inverse of the immediate extender.
// Optionally checks that the value is representable in the chosen format.
//
// Two-stage valid/ready pipeline with full backpressure. Stage 1 registers the
// request. Stage 2 registers the packed instruction and its error flag.
//
// Parameters:
//   CNT_W      width of enc_cnt / err_cnt
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake
//   in_immsrc              000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 11x illegal
//   in_imm                 immediate value (byte offset for B/J)
//   in_base                instruction supplying all non-immediate bits
//   out_valid / out_ready  result handshake
//   out_instr, out_err     packed instruction, not-representable/illegal flag
//   enc_cnt                output handshakes since reset (wraps)
//   err_cnt                output handshakes with out_err=1 (saturates)
// Build option:
//   IMM_PACKER_RANGE_CHECK_EN  when defined, out-of-range immediates set out_err.
//                              Otherwise only illegal formats set it.
module imm_packer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_immsrc,
   input  logic [31:0]      in_imm,
   input  logic [31:0]      in_base,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [2:0] FMT_I  = 3'b000;
   localparam logic [2:0] FMT_S  = 3'b001;
   localparam logic [2:0] FMT_B  = 3'b010;
   localparam logic [2:0] FMT_U  = 3'b011;
   localparam logic [2:0] FMT_J  = 3'b100;
   localparam logic [2:0] FMT_SH = 3'b101;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Out-of-range bits are dropped silently, so that a flagged result still
   // carries the truncated fields.
   function automatic logic [31:0] pack_fields(input logic [2:0]  src,
                                               input logic [31:0] imm,
                                               input logic [31:0] base);
      logic [31:0] w;
      w = base;
      case (src)
         FMT_I:  w[31:20] = imm[11:0];
         FMT_S: begin
            w[31:25] = imm[11:5];
            w[11:7]  = imm[4:0];
         end
         FMT_B: begin
            w[31]    = imm[12];
            w[7]     = imm[11];
            w[30:25] = imm[10:5];
            w[11:8]  = imm[4:1];
         end
         FMT_U:  w[31:12] = imm[31:12];
         FMT_J: begin
            w[31]    = imm[20];
            w[19:12] = imm[19:12];
            w[20]    = imm[11];
            w[30:21] = imm[10:1];
         end
         FMT_SH: w[24:20] = imm[4:0];
         default: w = base;
      endcase
      return w;
   endfunction

`ifdef IMM_PACKER_RANGE_CHECK_EN
   // A value fits a sign-extended field when all bits from the field's sign
   // bit upward are equal. B/J offsets must also be even.
   function automatic logic range_err(input logic [2:0]  src,
                                      input logic [31:0] imm);
      logic e;
      case (src)
         FMT_I, FMT_S: e = !((&imm[31:11]) | ~(|imm[31:11]));
         FMT_B:        e = imm[0] | !((&imm[31:12]) | ~(|imm[31:12]));
         FMT_U:        e = |imm[11:0];
         FMT_J:        e = imm[0] | !((&imm[31:20]) | ~(|imm[31:20]));
         FMT_SH:       e = |imm[31:5];
         default:      e = 1'b0;
      endcase
      return e;
   endfunction
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   logic        vld_p1;
   logic [2:0]  immsrc_p1;
   logic [31:0] imm_p1;
   logic [31:0] base_p1;
   logic        vld_p2;
   logic        adv_p1;
   logic        adv_p2;
   logic [31:0] instr_p1;
   logic        err_p1;
   logic        illegal_p1;

   assign adv_p2    = !vld_p2 | out_ready;
   assign adv_p1    = !vld_p1 | adv_p2;
   assign in_ready  = adv_p1;
   assign out_valid = vld_p2;

   assign instr_p1   = pack_fields(immsrc_p1, imm_p1, base_p1);
   assign illegal_p1 = immsrc_p1[2] & immsrc_p1[1];

`ifdef IMM_PACKER_RANGE_CHECK_EN
   assign err_p1 = illegal_p1 | range_err(immsrc_p1, imm_p1);
`else
   assign err_p1 = illegal_p1;
   // Bit 0 of a B/J offset has no field, so only the range check reads it.
   logic unused_imm_lsb;
   assign unused_imm_lsb = imm_p1[0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         immsrc_p1 <= 3'b000;
         imm_p1    <= 32'h0;
         base_p1   <= 32'h0;
         vld_p2    <= 1'b0;
         out_instr <= 32'h0;
         out_err   <= 1'b0;
         enc_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         // stage 1: capture request
         if (adv_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
               immsrc_p1 <= in_immsrc;
               imm_p1    <= in_imm;
               base_p1   <= in_base;
            end
         end
         // stage 2: capture packed result
         if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               out_instr <= instr_p1;
               out_err   <= err_p1;
            end
         end
         // counters advance on the output handshake only
         if (vld_p2 && out_ready) begin
            enc_cnt <= enc_cnt + CNT_ONE;
            if (out_err) err_cnt <= sat_inc(err_cnt);
         end
      end
   end

endmodule

// File: tb/tb_imm_packer.sv
// Testbench for imm_packer. A scoreboard queue is filled at each accepted
// request from a field-level reference model. A monitor drains it at each
// output handshake and also tracks the expected counter values.
// Representable results are also checked by re-extending them.
module tb_imm_packer;

`ifdef IMM_PACKER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_immsrc = 3'b000;
   logic [31:0] in_imm = 32'h0;
   logic [31:0] in_base = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic        out_err;
   logic [15:0] enc_cnt;
   logic [15:0] err_cnt;

   imm_packer #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_immsrc(in_immsrc), .in_imm(in_imm), .in_base(in_base),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err),
      .enc_cnt(enc_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [2:0]  src;
      logic [31:0] imm;
      bit          ok;
   } exp_t;

   exp_t        q[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] mdl_enc = 16'h0;
   logic [15:0] mdl_err = 16'h0;
   bit          done_rand = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: representability from numeric ranges, fields by masks/shifts.
   function automatic exp_t model(input logic [2:0] src, input logic [31:0] imm,
                                  input logic [31:0] b);
      exp_t e;
      int   sv;
      bit   legal;
      sv    = $signed(imm);
      legal = (src <= 3'd5);
      e.src = src;
      e.imm = imm;
      case (src)
         3'd0: begin
            e.instr = (b & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
            e.ok = (sv >= -2048) && (sv <= 2047);
         end
         3'd1: begin
            e.instr = (b & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            e.ok = (sv >= -2048) && (sv <= 2047);
         end
         3'd2: begin
            e.instr = (b & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7)
                    | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
            e.ok = (imm % 2 == 0) && (sv >= -4096) && (sv <= 4095);
         end
         3'd3: begin
            e.instr = (b & 32'h00000FFF) | (imm & 32'hFFFFF000);
            e.ok = (imm % 4096 == 0);
         end
         3'd4: begin
            e.instr = (b & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000FF000);
            e.ok = (imm % 2 == 0) && (sv >= -1048576) && (sv <= 1048575);
         end
         3'd5: begin
            e.instr = (b & 32'hFE0FFFFF) | ((imm & 32'h1F) << 20);
            e.ok = (imm < 32);
         end
         default: begin
            e.instr = b;
            e.ok = 1'b0;
         end
      endcase
      e.err = !legal || (RC && !e.ok);
      e.ok  = legal && e.ok;
      return e;
   endfunction

   // Immediate extender used for the round-trip check.
   function automatic logic [31:0] extend(input logic [31:0] ins, input logic [2:0] src);
      logic [31:0] s;
      case (src)
         3'd0: extend = 32'($signed(ins) >>> 20);
         3'd1: begin
            s = 32'($signed(ins) >>> 25);
            extend = (s << 5) | ((ins >> 7) & 32'h1F);
         end
         3'd2: begin
            s = ins[31] ? 32'hFFFFF000 : 32'h0;
            extend = s | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
         end
         3'd3: extend = ins & 32'hFFFFF000;
         3'd4: begin
            s = ins[31] ? 32'hFFF00000 : 32'h0;
            extend = s | (ins & 32'h000FF000) | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
         end
         default: extend = (ins >> 20) & 32'h1F;
      endcase
   endfunction

   // Monitor / scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("enc_cnt", 32'(enc_cnt), 32'(mdl_enc));
         chk("err_cnt", 32'(err_cnt), 32'(mdl_err));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'(out_valid), 32'h0);
            end else begin
               e = q.pop_front();
               chk("out_instr", out_instr, e.instr);
               chk("out_err", 32'(out_err), 32'(e.err));
               if (e.ok) chk("round_trip", extend(out_instr, e.src), e.imm);
               mdl_enc = mdl_enc + 16'd1;
               if (e.err && mdl_err != 16'hFFFF) mdl_err = mdl_err + 16'd1;
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_immsrc, in_imm, in_base));
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
      int n;
      bit acc;
      n = 0;
      in_immsrc = s; in_imm = i; in_base = b; in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'(acc), 32'h1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) chk({name, "_timeout"}, 32'(out_valid), 32'h1);
   endtask

   task automatic directed(input string name, input logic [2:0] s, input logic [31:0] i,
                           input logic [31:0] b, input logic [31:0] ei, input logic ee);
      send(s, i, b);
      wait_out(name);
      chk({name, "_instr"}, out_instr, ei);
      chk({name, "_err"}, 32'(out_err), 32'(ee));
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_left", 32'(q.size()), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        ea;
      logic [2:0]  src;
      logic [31:0] imm;
      int          k;

      // reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_err", 32'(out_err), 32'h0);
      chk("rst_enc_cnt", 32'(enc_cnt), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'h1);

      // latency: out_valid exactly two edges after the accepting edge
      send(3'd0, 32'hFFFFFFFF, 32'h00000013);
      chk("lat_1cyc_valid", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
      chk("lat_2cyc_valid", 32'(out_valid), 32'h1);
      chk("i_neg1_instr", out_instr, 32'hFFF00013);
      chk("i_neg1_err", 32'(out_err), 32'h0);
      @(posedge clk); #1;

      directed("b_16", 3'd2, 32'h00000010, 32'h00000063, 32'h00000863, 1'b0);
      directed("b_odd", 3'd2, 32'h00000003, 32'h00000063, 32'h00000163, RC);
      @(posedge clk); #1;
      chk("b_odd_err_cnt", 32'(err_cnt), 32'(RC));
      directed("u", 3'd3, 32'h12345000, 32'h000000B7, 32'h123450B7, 1'b0);
      directed("j", 3'd4, 32'h00000800, 32'h000000EF, 32'h001000EF, 1'b0);
      directed("i_2048", 3'd0, 32'h00000800, 32'h00000013, 32'h80000013, RC);
      directed("ill_111", 3'd7, 32'h00000005, 32'h12345678, 32'h12345678, 1'b1);
      directed("ill_110", 3'd6, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1);
      directed("shamt", 3'd5, 32'h0000001F, 32'h00001013, 32'h01F01013, 1'b0);
      drain();

      // asynchronous reset with two items in flight
      out_ready = 1'b0;
      send(3'd0, 32'h00000001, 32'h00000013);
      send(3'd0, 32'h00000002, 32'h00000013);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_enc_cnt", 32'(enc_cnt), 32'h0);
      chk("arst_err_cnt", 32'(err_cnt), 32'h0);
      chk("arst_out_instr", out_instr, 32'h0);
      q.delete();
      mdl_enc = 16'h0;
      mdl_err = 16'h0;
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_no_output", 32'(out_valid), 32'h0);
      end
      @(posedge clk); #1;

      // backpressure: three back-to-back requests against a stalled output
      out_ready = 1'b0;
      ea = model(3'd1, 32'h00000123, 32'h00002023);
      send(3'd1, 32'h00000123, 32'h00002023);
      send(3'd2, 32'hFFFFFFFE, 32'h00000063);
      in_immsrc = 3'd3; in_imm = 32'hABCDE000; in_base = 32'h00000037; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("stall_in_ready", 32'(in_ready), 32'h0);
         chk("stall_out_instr", out_instr, ea.instr);
         chk("stall_out_valid", 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out0", 32'(out_valid), 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("release_out1", 32'(out_valid), 32'h1);
      @(negedge clk);
      chk("release_out2", 32'(out_valid), 32'h1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("stall_enc_cnt", 32'(enc_cnt), 32'h3);
      drain();

      // random traffic with random backpressure
      fork
         begin
            for (k = 0; k < 10000; k++) begin
               src = ($urandom_range(9) < 8) ? 3'($urandom_range(5)) : 3'(6 + $urandom_range(1));
               imm = $urandom;
               case ($urandom_range(3))
                  0: ;
                  1: begin
                     imm = 32'($signed(imm) >>> $urandom_range(31, 11));
                     if ($urandom_range(1) == 1) imm[0] = 1'b0;
                  end
                  2: imm = imm & 32'hFFFFF000;
                  default: imm = 32'($urandom_range(40));
               endcase
               if ($urandom_range(7) == 0) begin
                  @(posedge clk); #1;
               end
               send(src, imm, $urandom);
            end
            done_rand = 1'b1;
         end
         begin
            while (!done_rand) begin
               out_ready = ($urandom_range(3) != 0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
